xnor_seq_arb: RTL and testbench

Two-requester sequencer for the shared 4-bit XNOR slice (`xnor_4b`). It accepts 16-bit operand pairs from two requesters and arbitrates between them round-robin. It computes the bitwise XNOR nibble by nibble through a single internal `xnor_4b` instance and returns the assembled result with a done pulse. It lets one 4-bit logic slice serve wider datapath operations issued from two sources.

---
 rtl/xnor_seq_arb.sv | 137 +++++++++++++
 tb/tb_xnor_seq_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_seq_arb.sv
// rtl/xnor_seq_arb.sv - two-requester round-robin sequencer over one 4-bit XNOR slice
// Optional feature macro: XNOR_SEQ_PARITY_EN (adds registered parity output par)

module xnor_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = ~(a ^ b);
endmodule

module xnor_seq_arb #(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [4*NIB-1:0]   x0,
  input  logic [4*NIB-1:0]   y0,
  input  logic [4*NIB-1:0]   x1,
  input  logic [4*NIB-1:0]   y1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               id,
  output logic [4*NIB-1:0]   out
`ifdef XNOR_SEQ_PARITY_EN
  ,
  output logic               par
`endif
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           pri;
  logic           own;
  logic [W-1:0]   xa;
  logic [W-1:0]   ya;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic [IW-1:0]  base;
  logic [3:0]     nib_x;
  logic [3:0]     nib_y;
  logic [3:0]     nib_q;
  logic           can_grant;

  // Grants are only offered from IDLE and never while reset is asserted
  assign can_grant = (state == S_IDLE) && rst_n;
  assign gnt0      = can_grant & req0 & (~req1 | ~pri);
  assign gnt1      = can_grant & req1 & (~req0 | pri);

  assign base = IW'(cnt) << 2;

  xnor_4b u_slice (
    .a (nib_x),
    .b (nib_y),
    .y (nib_q)
  );

  // Select the active nibble and merge the slice result into the accumulator
  always_comb begin
    nib_x          = xa[base +: 4];
    nib_y          = ya[base +: 4];
    acc_next       = acc;
    acc_next[base +: 4] = nib_q;
  end

  // Sequencer: capture on grant, one nibble per RUN cycle, publish on entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pri   <= 1'b0;
      own   <= 1'b0;
      xa    <= '0;
      ya    <= '0;
      acc   <= '0;
      out   <= '0;
      id    <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
`ifdef XNOR_SEQ_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt0 | gnt1) begin
            xa    <= gnt1 ? x1 : x0;
            ya    <= gnt1 ? y1 : y0;
            own   <= gnt1;
            pri   <= gnt0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (cnt == CNT_LAST) begin
            out   <= acc_next;
            id    <= own;
`ifdef XNOR_SEQ_PARITY_EN
            par   <= ^acc_next;
`endif
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_seq_arb.sv
// tb/tb_xnor_seq_arb.sv - scoreboard bench for xnor_seq_arb

module tb_xnor_seq_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] x0 = '0;
  logic [15:0] y0 = '0;
  logic [15:0] x1 = '0;
  logic [15:0] y1 = '0;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic        done;
  logic        id;
  logic [15:0] out;
`ifdef XNOR_SEQ_PARITY_EN
  logic        par;
`endif

  xnor_seq_arb #(.NIB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .req1  (req1),
    .x0    (x0),
    .y0    (y0),
    .x1    (x1),
    .y1    (y1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .busy  (busy),
    .done  (done),
    .id    (id),
    .out   (out)
`ifdef XNOR_SEQ_PARITY_EN
    ,
    .par   (par)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [15:0] out;
    logic        par;
    int          dc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic [15:0] prev_out = '0;
  logic        prev_rst = 1'b0;
  logic        prev_done = 1'b0;

  // Monitor: pop and compare on every done, and watch out/done invariants
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: cycle %0d out=%h id=%0d, no operation pending", cyc, out, id);
      end else begin
        e = sb.pop_front();
        if (out !== e.out || id !== e.id || cyc != e.dc) begin
          miscompares++;
          $display("FAIL done_result: got out=%h id=%0d cycle=%0d, want out=%h id=%0d cycle=%0d",
                   out, id, cyc, e.out, e.id, e.dc);
        end
`ifdef XNOR_SEQ_PARITY_EN
        vectors++;
        if (par !== e.par) begin
          miscompares++;
          $display("FAIL done_par: got %0d want %0d", par, e.par);
        end
`endif
      end
    end
    if (rst_n && prev_rst && !done && out !== prev_out) begin
      miscompares++;
      $display("FAIL out_hold: out changed %h -> %h without done at cycle %0d", prev_out, out, cyc);
    end
    if (done && prev_done) begin
      miscompares++;
      $display("FAIL done_double: done high two cycles at cycle %0d", cyc);
    end
    prev_out  = out;
    prev_rst  = rst_n;
    prev_done = done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a grant, check which requester got it, and queue the expected result
  task automatic issue(input bit who, input logic [15:0] exp_out, input bit drop,
                       input bit expect_done, input int maxw, output int gc);
    exp_t e;
    gc = -1;
    for (int i = 0; i < maxw; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        check("grant_owner", {30'd0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
        gc = cyc;
        if (expect_done) begin
          e.id  = who;
          e.out = exp_out;
          e.par = ^exp_out;
          e.dc  = cyc + 5;
          sb.push_back(e);
        end
        break;
      end
    end
    if (gc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: no grant for requester %0d within %0d cycles", who, maxw);
    end
    step();
    if (drop) begin
      if (who) req1 = 1'b0;
      else     req0 = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: %0d operations still pending", sb.size());
      sb.delete();
    end
    step();
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    @(negedge clk);
    check("gnt_in_reset", {30'd0, gnt1, gnt0}, 32'd0);
    step();
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    check("reset_state", {14'd0, busy, done, id, out}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int g0, g1, g2, g3, gr;

    step();
    do_reset();

    // Single op
    x0 = 16'h1234; y0 = 16'h1235; req0 = 1'b1;
    issue(1'b0, 16'hFFFE, 1'b1, 1'b1, 1, g0);
    wait_idle();

    // Output hold while a new op runs
    x0 = 16'hFFFF; y0 = 16'h0000; req0 = 1'b1;
    issue(1'b0, 16'h0000, 1'b1, 1'b1, 2, g0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("out_hold_run", {16'd0, out}, 32'h0000_FFFE);
    end
    wait_idle();

    // Simultaneous requests after reset
    do_reset();
    x0 = 16'hBEEF; y0 = 16'hBEEF; x1 = 16'hA5A5; y1 = 16'h5A5A;
    req0 = 1'b1; req1 = 1'b1;
    issue(1'b0, 16'hFFFF, 1'b1, 1'b1, 1, g0);
    issue(1'b1, 16'h0000, 1'b1, 1'b1, 8, g1);
    check("simul_interval", g1 - g0, 32'd6);
    wait_idle();

    // Round-robin fairness, both held for four operations
    do_reset();
    x0 = 16'h0000; y0 = 16'h0F0F; x1 = 16'hFFFF; y1 = 16'h1234;
    req0 = 1'b1; req1 = 1'b1;
    issue(1'b0, 16'hF0F0, 1'b0, 1'b1, 1, g0);
    issue(1'b1, 16'h1234, 1'b0, 1'b1, 8, g1);
    issue(1'b0, 16'hF0F0, 1'b0, 1'b1, 8, g2);
    issue(1'b1, 16'h1234, 1'b1, 1'b1, 8, g3);
    req0 = 1'b0;
    check("rr_interval_01", g1 - g0, 32'd6);
    check("rr_interval_12", g2 - g1, 32'd6);
    check("rr_interval_23", g3 - g2, 32'd6);
    wait_idle();

    // Request during busy
    x0 = 16'h00FF; y0 = 16'h0000; x1 = 16'h3C3C; y1 = 16'h3C3C;
    req0 = 1'b1;
    issue(1'b0, 16'hFF00, 1'b1, 1'b1, 2, g0);
    step();
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_gnt_busy", {31'd0, gnt1}, 32'd0);
    end
    issue(1'b1, 16'hFFFF, 1'b1, 1'b1, 3, g1);
    check("busy_req_grant_cycle", g1 - g0, 32'd6);
    wait_idle();

    // Reset mid-operation at cnt==2
    x0 = 16'h1234; y0 = 16'h1235; req0 = 1'b1;
    issue(1'b0, 16'h0000, 1'b0, 1'b0, 2, g0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #3;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out", {16'd0, out}, 32'd0);
    issue(1'b0, 16'hFFFE, 1'b1, 1'b1, 1, gr);
    check("midrst_regrant_cycle", gr - g0, 32'd4);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
